// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input peripheral: register offsets
// within the GPIO load/store region and the address bit that selects it.
package gpio_pkg;

  localparam logic [1:0] GPIO_LEVEL = 2'd0;
  localparam logic [1:0] GPIO_RISE  = 2'd1;
  localparam logic [1:0] GPIO_FALL  = 2'd2;
  localparam logic [1:0] GPIO_MASK  = 2'd3;

  localparam int GPIO_REGION_BIT = 31;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin: two-flop synchronizer followed by a stability counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // The edge event fires combinationally on the same edge that level_q flips.
  assign accept = (sync2_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = accept & sync2_q;
  assign fall_o  = accept & ~sync2_q;

endmodule

// File: rtl/gpio_in_reader.sv
// GPIO input block: debounced pin levels, sticky W1C edge flags, interrupt
// mask and a registered read port feeding the register-file write-back mux.
module gpio_in_reader
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins_in,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [1:0]       reg_sel,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (pins_in[gi]),
      .level_o(level[gi]),
      .rise_o (rise_evt[gi]),
      .fall_o (fall_evt[gi])
    );
  end

  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] wr_bits;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             irq_q, irq_d;
  logic             unused_wr_data;

  assign wr_bits        = wr_data[WIDTH-1:0];
  assign unused_wr_data = ^wr_data;

  always_comb begin
    rise_d    = rise_q;
    fall_d    = fall_q;
    mask_d    = mask_q;
    rd_data_d = rd_data_q;

    if (wr_en && (reg_sel == GPIO_RISE)) rise_d = rise_q & ~wr_bits;
    if (wr_en && (reg_sel == GPIO_FALL)) fall_d = fall_q & ~wr_bits;
    if (wr_en && (reg_sel == GPIO_MASK)) mask_d = wr_bits;
    // New events are OR'd in last so a same-cycle set beats a clear.
    rise_d = rise_d | rise_evt;
    fall_d = fall_d | fall_evt;

    if (rd_en) begin
      rd_data_d = '0;
      case (reg_sel)
        GPIO_LEVEL: rd_data_d[WIDTH-1:0] = level;
        GPIO_RISE:  rd_data_d[WIDTH-1:0] = rise_q;
        GPIO_FALL:  rd_data_d[WIDTH-1:0] = fall_q;
        default:    rd_data_d[WIDTH-1:0] = mask_q;
      endcase
    end

    irq_d = |((rise_q | fall_q) & mask_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q    <= '0;
      fall_q    <= '0;
      mask_q    <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      mask_q    <= mask_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_data = rd_data_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_in_reader.sv
// Directed bench for gpio_in_reader (WIDTH=8, DEBOUNCE_CYCLES=4); read
// results go through an expected-value queue popped when rd_data is valid.
module tb_gpio_in_reader;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;
  localparam int CW    = 3;

  localparam logic [1:0] R_LEVEL = 2'd0;
  localparam logic [1:0] R_RISE  = 2'd1;
  localparam logic [1:0] R_FALL  = 2'd2;
  localparam logic [1:0] R_MASK  = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pins_in;
  logic             rd_en;
  logic             wr_en;
  logic [1:0]       reg_sel;
  logic [31:0]      wr_data;
  logic [31:0]      rd_data;
  logic             irq;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  gpio_in_reader #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pins_in(pins_in),
    .rd_en  (rd_en),
    .wr_en  (wr_en),
    .reg_sel(reg_sel),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    reg_sel = sel;
    rd_en   = 1'b1;
    step(1);
    rd_en = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, rd_data, e);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    reg_sel = sel;
    wr_data = data;
    wr_en   = 1'b1;
    step(1);
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  initial begin
    rst     = 1'b0;
    pins_in = '0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    reg_sel = '0;
    wr_data = '0;
    step(2);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    rst = 1'b1;

    // Build up non-zero state, then reset asynchronously between edges.
    pins_in = 8'hFF;
    step(8);
    rd(R_LEVEL, 32'h0000_00FF, "pre_reset_level");
    wr(R_MASK, 32'h0000_00FF);
    step(2);
    check("pre_reset_irq", {31'd0, irq}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_rd_data", rd_data, 32'h0);
    check("async_reset_irq", {31'd0, irq}, 32'h0);
    step(2);
    rst = 1'b1;
    step(5);
    rd(R_LEVEL, 32'h0000_0000, "level_edge6_preupdate");
    rd(R_LEVEL, 32'h0000_00FF, "level_after_release");
    rd(R_RISE, 32'h0000_00FF, "rise_after_release");
    rd(R_MASK, 32'h0000_0000, "mask_after_reset");
    check("irq_mask_cleared", {31'd0, irq}, 32'h0);

    // Glitch rejection on pin0.
    pins_in = 8'h00;
    step(8);
    wr(R_RISE, 32'hFFFF_FFFF);
    wr(R_FALL, 32'hFFFF_FFFF);
    rd(R_RISE, 32'h0, "rise_cleared");
    pins_in = 8'h01;
    step(3);
    pins_in = 8'h00;
    step(8);
    rd(R_LEVEL, 32'h0, "glitch_level");
    rd(R_RISE, 32'h0, "glitch_rise");
    pins_in = 8'h01;
    step(8);
    rd(R_LEVEL, 32'h0000_0001, "stable_level");
    rd(R_RISE, 32'h0000_0001, "stable_rise");

    // Write-one-to-clear, and set beating clear in the same cycle.
    pins_in = 8'h05;
    step(8);
    rd(R_RISE, 32'h0000_0005, "rise_05");
    wr(R_RISE, 32'h0000_0004);
    rd(R_RISE, 32'h0000_0001, "w1c_partial");
    pins_in = 8'h04;
    step(8);
    wr(R_RISE, 32'h0000_0001);
    rd(R_RISE, 32'h0000_0000, "w1c_bit0");
    pins_in = 8'h05;
    step(5);
    wr(R_RISE, 32'h0000_0001);
    rd(R_RISE, 32'h0000_0001, "set_wins_over_clear");
    rd(R_FALL, 32'h0000_0001, "fall_pin0");

    // Read latency and hold.
    pins_in = 8'hA5;
    step(8);
    rd(R_LEVEL, 32'h0000_00A5, "level_A5");
    pins_in = 8'h00;
    step(8);
    check("rd_data_hold", rd_data, 32'h0000_00A5);
    rd(R_LEVEL, 32'h0000_0000, "level_00");

    // Interrupt generation on a masked fall.
    wr(R_RISE, 32'hFF);
    wr(R_FALL, 32'hFF);
    wr(R_MASK, 32'h0000_0102);
    rd(R_MASK, 32'h0000_0002, "mask_02");
    pins_in = 8'h02;
    step(8);
    wr(R_RISE, 32'hFF);
    step(2);
    check("irq_idle", {31'd0, irq}, 32'h0);
    pins_in = 8'h00;
    step(6);
    check("irq_lags_flag", {31'd0, irq}, 32'h0);
    step(1);
    check("irq_set", {31'd0, irq}, 32'h1);
    rd(R_FALL, 32'h0000_0002, "fall_pin1");
    wr(R_FALL, 32'h0000_0002);
    check("irq_after_clear_edge", {31'd0, irq}, 32'h1);
    step(1);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    pins_in = 8'h08;
    step(8);
    pins_in = 8'h00;
    step(8);
    check("irq_unmasked_fall", {31'd0, irq}, 32'h0);
    rd(R_FALL, 32'h0000_0008, "fall_pin3");
    rd(R_RISE, 32'h0000_0008, "rise_pin3");

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
